// File: rtl/muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : muldiv_unit                                                  |
// | Description : EX-stage multiply/divide unit with architectural HI/LO.      |
// |               The result is computed when the operation is accepted.       |
// |               HI/LO are then written after a fixed multi-cycle latency.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module muldiv_unit #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  MulDiv_ex,
  input  logic        multu_ex,
  input  logic        MThilo_ex,
  input  logic        mthi_ex,
  input  logic [1:0]  MFhilo_ex,
  input  logic [31:0] rd1_ex,
  input  logic [31:0] rd2_ex,
  output logic        busy,
  output logic [31:0] hilo_out
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic [31:0]      hi, lo;
  logic [31:0]      pend_hi, pend_lo;
  logic             pend_we;
  logic [CNT_W-1:0] cnt;

  logic        idle, is_mult, is_div, start;
  logic [63:0] ext_a, ext_b, prod;
  logic        neg_a, neg_b;
  logic [31:0] abs_a, abs_b, safe_b, uquot, urem, quot, rem;

  assign idle    = (cnt == CNT_ZERO);
  assign is_mult = (MulDiv_ex == 2'b01);
  assign is_div  = (MulDiv_ex == 2'b10);
  // Code 11 is reserved and behaves like no operation.
  assign start   = idle & (is_mult | is_div);
  assign busy    = start | ~idle;

  // Operand conditioning, product and quotient/remainder for the op being accepted.
  always_comb begin
    // Sign- or zero-extension gives the correct 64-bit product from a single unsigned multiply.
    ext_a  = multu_ex ? {32'h0, rd1_ex} : {{32{rd1_ex[31]}}, rd1_ex};
    ext_b  = multu_ex ? {32'h0, rd2_ex} : {{32{rd2_ex[31]}}, rd2_ex};
    prod   = ext_a * ext_b;
    // Signed divide on magnitudes; 0x80000000 is its own magnitude as an unsigned value,
    // so the overflow case 0x80000000 / -1 naturally yields 0x80000000 remainder 0.
    neg_a  = ~multu_ex & rd1_ex[31];
    neg_b  = ~multu_ex & rd2_ex[31];
    abs_a  = neg_a ? (32'h0 - rd1_ex) : rd1_ex;
    abs_b  = neg_b ? (32'h0 - rd2_ex) : rd2_ex;
    // Avoid a divide-by-zero in the datapath; the result is discarded in that case.
    safe_b = (rd2_ex == 32'h0) ? 32'h1 : abs_b;
    uquot  = abs_a / safe_b;
    urem   = abs_a % safe_b;
    quot   = (neg_a ^ neg_b) ? (32'h0 - uquot) : uquot;
    rem    = neg_a ? (32'h0 - urem) : urem;
  end

  // Latency counter, pending result and HI/LO register updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi      <= 32'h0;
      lo      <= 32'h0;
      pend_hi <= 32'h0;
      pend_lo <= 32'h0;
      pend_we <= 1'b0;
      cnt     <= CNT_ZERO;
    end else if (start) begin
      // Any mt arriving alongside a start is dropped.
      if (is_mult) begin
        cnt     <= MULT_CNT;
        pend_hi <= prod[63:32];
        pend_lo <= prod[31:0];
        pend_we <= 1'b1;
      end else begin
        cnt     <= DIV_CNT;
        pend_hi <= rem;
        pend_lo <= quot;
        pend_we <= (rd2_ex != 32'h0);
      end
    end else if (!idle) begin
      // New ops and mt writes are ignored while an operation is in flight.
      cnt <= cnt - CNT_ONE;
      if (cnt == CNT_ONE && pend_we) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else if (MThilo_ex) begin
      if (mthi_ex) hi <= rd1_ex;
      else         lo <= rd1_ex;
    end
  end

  // Read port for mfhi/mflo; reflects the current architectural HI/LO.
  always_comb begin
    case (MFhilo_ex)
      2'b01:   hilo_out = hi;
      2'b10:   hilo_out = lo;
      default: hilo_out = 32'h0;
    endcase
  end

endmodule
`default_nettype wire
